mmio_bridge: RTL and testbench

Memory-mapped I/O bridge between the RISC-V core's load/store port and the GPIO peripheral at 0x2000_0000. It accepts one core request at a time over a valid/ready handshake and decodes the address. It drives the GPIO's single-cycle `gpio_en`/`write_enable` strobes, performs read-modify-write for partial-byte stores, captures GPIO read data, and returns a response over a second valid/ready handshake. Unmapped or misaligned accesses complete with an error and never touch the GPIO.

---
 rtl/mmio_pkg.sv | 31 +++
 rtl/mmio_bridge.sv | 175 +++++++++++++++++
 tb/tb_mmio_bridge.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared types and helpers for the core-to-GPIO MMIO bridge.
package mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [31:0] GPIO_BASE_DEFAULT = 32'h2000_0000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RD_ISSUE   = 3'd1,
    ST_RD_CAPTURE = 3'd2,
    ST_WR_ISSUE   = 3'd3,
    ST_RESP       = 3'd4
  } mmio_state_t;

  // Byte-lane merge: enabled lanes come from new_w, the rest from old_w.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_bridge.sv
// Bridges single core load/store requests onto the GPIO strobe interface,
// with read-modify-write for partial stores and error completion otherwise.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    GPIO_BASE = ADDR_W'(GPIO_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              gpio_en,
  output logic              gpio_write_enable,
  output logic [DATA_W-1:0] gpio_wdata,
  input  logic [DATA_W-1:0] gpio_rdata
);

  mmio_state_t       state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              gpio_en_q, gpio_en_d;
  logic              gpio_we_q, gpio_we_d;
  logic [DATA_W-1:0] gpio_wdata_q, gpio_wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic addr_hit;
  logic addr_misaligned;

  // Decode is done on the live request address in the accept cycle.
  assign addr_hit        = (req_addr == GPIO_BASE);
  assign addr_misaligned = (req_addr[1:0] != 2'b00);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    gpio_en_d    = 1'b0;
    gpio_we_d    = 1'b0;
    gpio_wdata_d = '0;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          we_d        = req_we;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          if (!addr_hit || addr_misaligned) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (!req_we) begin
            state_d   = ST_RD_ISSUE;
            gpio_en_d = 1'b1;
          end else if (req_wstrb == '1) begin
            state_d      = ST_WR_ISSUE;
            gpio_en_d    = 1'b1;
            gpio_we_d    = 1'b1;
            gpio_wdata_d = req_wdata;
          end else if (req_wstrb == '0) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end else begin
            // Partial store: fetch the current word first.
            state_d   = ST_RD_ISSUE;
            gpio_en_d = 1'b1;
          end
        end
      end

      ST_RD_ISSUE: begin
        state_d = ST_RD_CAPTURE;
      end

      ST_RD_CAPTURE: begin
        if (we_q) begin
          state_d      = ST_WR_ISSUE;
          gpio_en_d    = 1'b1;
          gpio_we_d    = 1'b1;
          gpio_wdata_d = merge_bytes(gpio_rdata, wdata_q, wstrb_q);
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = gpio_rdata;
        end
      end

      ST_WR_ISSUE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
    endcase
  end

  // State, output and request-latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      gpio_en_q    <= 1'b0;
      gpio_we_q    <= 1'b0;
      gpio_wdata_q <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      gpio_en_q    <= gpio_en_d;
      gpio_we_q    <= gpio_we_d;
      gpio_wdata_q <= gpio_wdata_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_err           = rsp_err_q;
  assign gpio_en           = gpio_en_q;
  assign gpio_write_enable = gpio_we_q;
  assign gpio_wdata        = gpio_wdata_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with a behavioural single-register GPIO.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        gpio_en;
  logic        gpio_write_enable;
  logic [31:0] gpio_wdata;
  logic [31:0] gpio_rdata = 32'h0;

  logic [31:0] gpio_reg = 32'h0;
  logic        prev_en = 1'b0;
  logic        gpio_viol = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mmio_bridge dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_addr          (req_addr),
    .req_we            (req_we),
    .req_wdata         (req_wdata),
    .req_wstrb         (req_wstrb),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .gpio_en           (gpio_en),
    .gpio_write_enable (gpio_write_enable),
    .gpio_wdata        (gpio_wdata),
    .gpio_rdata        (gpio_rdata)
  );

  // GPIO data register: write on strobe, registered read data one cycle later.
  always @(posedge clk) begin
    if (gpio_en && gpio_write_enable) gpio_reg <= gpio_wdata;
    if (gpio_en && !gpio_write_enable) gpio_rdata <= gpio_reg;
  end

  // Sticky flag for back-to-back strobes or stray write qualifiers.
  always @(negedge clk) begin
    prev_en <= gpio_en;
    if (gpio_en && prev_en) gpio_viol <= 1'b1;
    if (!gpio_en && (gpio_write_enable || gpio_wdata != 32'h0)) gpio_viol <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, then watch cycles 1.. until the first rsp_valid.
  task automatic txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                     input logic [3:0] strb, output int lat, output int n_rd,
                     output int n_wr, output int rd_cyc, output logic [31:0] last_wd,
                     output logic [31:0] rdata, output logic err);
    int cyc;
    lat = 99; n_rd = 0; n_wr = 0; rd_cyc = 0; last_wd = 32'h0; rdata = 32'hx; err = 1'bx;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_we = we; req_wdata = wd; req_wstrb = strb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      if (gpio_en) begin
        if (gpio_write_enable) begin n_wr++; last_wd = gpio_wdata; end
        else begin n_rd++; rd_cyc = cyc; end
      end
      if (rsp_valid) begin
        lat = cyc; rdata = rsp_rdata; err = rsp_err;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  // Release the response and confirm the bridge reopens the next cycle.
  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".req_ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, ".rsp_valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_rd, n_wr, rd_cyc;
    logic [31:0] wd, rd;
    logic err;
    int seen_wr, seen_rsp;

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.gpio_en",   32'(gpio_en), 32'd0);
    chk("rst.gpio_we",   32'(gpio_write_enable), 32'd0);
    chk("rst.gpio_wdata", gpio_wdata, 32'h0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_err",   32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    // Full store
    txn(32'h2000_0000, 1'b1, 32'hA5A5_1234, 4'hF, lat, n_rd, n_wr, rd_cyc, wd, rd, err);
    chk("fst.lat", 32'(lat), 32'd2);
    chk("fst.n_wr", 32'(n_wr), 32'd1);
    chk("fst.n_rd", 32'(n_rd), 32'd0);
    chk("fst.wdata", wd, 32'hA5A5_1234);
    chk("fst.err", 32'(err), 32'd0);
    chk("fst.rdata", rd, 32'h0);
    finish_rsp("fst");

    // Load
    txn(32'h2000_0000, 1'b0, 32'h0, 4'h0, lat, n_rd, n_wr, rd_cyc, wd, rd, err);
    chk("ld.lat", 32'(lat), 32'd3);
    chk("ld.rd_cyc", 32'(rd_cyc), 32'd1);
    chk("ld.n_wr", 32'(n_wr), 32'd0);
    chk("ld.rdata", rd, 32'hA5A5_1234);
    chk("ld.err", 32'(err), 32'd0);
    finish_rsp("ld");

    // Partial store, low byte
    txn(32'h2000_0000, 1'b1, 32'h0000_00FF, 4'b0001, lat, n_rd, n_wr, rd_cyc, wd, rd, err);
    chk("pst.lat", 32'(lat), 32'd4);
    chk("pst.n_rd", 32'(n_rd), 32'd1);
    chk("pst.n_wr", 32'(n_wr), 32'd1);
    chk("pst.wdata", wd, 32'hA5A5_12FF);
    chk("pst.rdata", rd, 32'h0);
    chk("pst.err", 32'(err), 32'd0);
    finish_rsp("pst");

    // Partial store, lanes 3 and 1
    txn(32'h2000_0000, 1'b1, 32'h1122_3344, 4'b1010, lat, n_rd, n_wr, rd_cyc, wd, rd, err);
    chk("pst2.lat", 32'(lat), 32'd4);
    chk("pst2.wdata", wd, 32'h11A5_33FF);
    finish_rsp("pst2");

    // Zero-strobe store leaves the GPIO alone
    txn(32'h2000_0000, 1'b1, 32'hDEAD_BEEF, 4'h0, lat, n_rd, n_wr, rd_cyc, wd, rd, err);
    chk("zst.lat", 32'(lat), 32'd1);
    chk("zst.strobes", 32'(n_rd + n_wr), 32'd0);
    chk("zst.err", 32'(err), 32'd0);
    finish_rsp("zst");

    txn(32'h2000_0000, 1'b0, 32'h0, 4'h0, lat, n_rd, n_wr, rd_cyc, wd, rd, err);
    chk("ld2.rdata", rd, 32'h11A5_33FF);
    finish_rsp("ld2");

    // Unmapped load
    txn(32'h2000_0004, 1'b0, 32'h0, 4'h0, lat, n_rd, n_wr, rd_cyc, wd, rd, err);
    chk("unm.lat", 32'(lat), 32'd1);
    chk("unm.err", 32'(err), 32'd1);
    chk("unm.rdata", rd, 32'h0);
    chk("unm.strobes", 32'(n_rd + n_wr), 32'd0);
    finish_rsp("unm");

    // Misaligned store inside the window
    txn(32'h2000_0002, 1'b1, 32'hFFFF_FFFF, 4'hF, lat, n_rd, n_wr, rd_cyc, wd, rd, err);
    chk("mis.lat", 32'(lat), 32'd1);
    chk("mis.err", 32'(err), 32'd1);
    chk("mis.rdata", rd, 32'h0);
    chk("mis.strobes", 32'(n_rd + n_wr), 32'd0);
    finish_rsp("mis");

    // Backpressure on a load response
    rsp_ready = 1'b0;
    txn(32'h2000_0000, 1'b0, 32'h0, 4'h0, lat, n_rd, n_wr, rd_cyc, wd, rd, err);
    chk("bp.lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp.rdata", rsp_rdata, 32'h11A5_33FF);
      chk("bp.req_ready", 32'(req_ready), 32'd0);
      chk("bp.gpio_en", 32'(gpio_en), 32'd0);
    end
    finish_rsp("bp");

    // Reset while the partial store's read strobe is out
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h2000_0000; req_we = 1'b1;
    req_wdata = 32'h0000_0077; req_wstrb = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rab.rd_issue", 32'(gpio_en & ~gpio_write_enable), 32'd1);
    rst_n = 1'b0;
    seen_wr = 0; seen_rsp = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (gpio_en && gpio_write_enable) seen_wr++;
      if (rsp_valid) seen_rsp++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (gpio_en && gpio_write_enable) seen_wr++;
      if (rsp_valid) seen_rsp++;
    end
    chk("rab.no_write", 32'(seen_wr), 32'd0);
    chk("rab.no_rsp", 32'(seen_rsp), 32'd0);
    chk("rab.req_ready", 32'(req_ready), 32'd1);
    chk("rab.gpio_reg", gpio_reg, 32'h11A5_33FF);

    chk("gpio.protocol", 32'(gpio_viol), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
